// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter between NUM_REQ byte-stream requesters. A
// requester wins the transmitter by round robin. It then keeps the grant for
// a whole burst, up to and including the byte it marks with req_last. Each
// byte is loaded into tx_data and announced with a one-cycle tx_start pulse.
// The next byte is taken only after the transmitter reports tx_done.
//
// State table:
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | no owner; pick the next requester in round-robin order
//   S_SEND  | owner fixed; wait for its byte (req_ready follows req_valid)
//   S_START | byte captured; tx_start high for this single cycle
//   S_WAIT  | transmitter busy; wait for tx_done
//
// Ports:
//   clk          in   system clock, rising edge
//   areset       in   synchronous active-high reset
//   req_valid    in   [NUM_REQ]     requester i presents a byte
//   req_data     in   [8*NUM_REQ]   byte of requester i at [8i+7:8i]
//   req_last     in   [NUM_REQ]     presented byte closes requester i's burst
//   req_ready    out  [NUM_REQ]     one-hot or zero; byte of i accepted
//   tx_start     out  start pulse to the transmitter
//   tx_data      out  [8]           byte to the transmitter
//   tx_done      in   transmitter frame-complete pulse
//   grant_valid  out  a burst owner exists
//   grant_id     out  [GW]          current or most recent owner
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int GW      = 2
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_done,
    output logic                 grant_valid,
    output logic [GW-1:0]        grant_id
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_START = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_grant_q, last_grant_d;
    logic [7:0]    data_q, data_d;
    logic          last_q, last_d;

    // View of the currently granted requester.
    logic          sel_valid;
    logic          sel_last;
    logic [7:0]    sel_data;

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == GW'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[8*i +: 8];
            end
        end
    end

    // Round robin: each valid requester gets a distance from last_grant+1
    // (wrapping modulo NUM_REQ); the smallest distance wins. Requester
    // last_grant itself has the largest distance, so it goes last.
    logic [GW-1:0] rr_winner;
    int            rr_best;
    int            rr_dist;

    always_comb begin
        rr_winner = '0;
        rr_best   = NUM_REQ;
        rr_dist   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rr_dist = (i + NUM_REQ - 1 - int'(last_grant_q)) % NUM_REQ;
            if (req_valid[i] && (rr_dist < rr_best)) begin
                rr_best   = rr_dist;
                rr_winner = GW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_REQ - 1);
            data_q       <= 8'h00;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            data_q       <= data_d;
            last_q       <= last_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        data_d       = data_q;
        last_d       = last_q;

        case (state_q)
            S_IDLE: begin
                if (|req_valid) begin
                    grant_d = rr_winner;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                // The lock is held while the owner stalls; nobody else is served.
                if (sel_valid) begin
                    data_d  = sel_data;
                    last_d  = sel_last;
                    state_d = S_START;
                end
            end
            S_START: begin
                // A done pulse here cannot belong to this byte; ignore it.
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (tx_done) begin
                    if (last_q) begin
                        last_grant_d = grant_q;
                        state_d      = S_IDLE;
                    end else begin
                        state_d = S_SEND;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (state_q == S_SEND) && (grant_q == GW'(i)) && req_valid[i];
        end
    end

    assign tx_start    = (state_q == S_START);
    assign tx_data     = data_q;
    assign grant_valid = (state_q != S_IDLE);
    assign grant_id    = grant_q;

    a_ready_onehot : assert property (@(posedge clk) disable iff (areset) $onehot0(req_ready));
    a_start_single : assert property (@(posedge clk) disable iff (areset) tx_start |=> !tx_start);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Drives four requesters from per-requester byte queues and plays the
// transmitter (done pulse some cycles after each start, plus stray pulses).
// Expected behaviour comes from a cycle-level reference: round-robin picks
// from the requester set, per-byte acceptance/start/done ordering, and burst
// ownership. Inputs are applied 1 time unit after the rising edge; outputs
// are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              areset;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_done;
    logic              grant_valid;
    logic [1:0]        grant_id;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(NREQ), .GW(2)) dut (
        .clk         (clk),
        .areset      (areset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Requester byte queues: {last, data}.
    logic [8:0] rq [NREQ][$];
    int hold_off [NREQ];

    // Stimulus knobs.
    int p_valid, p_stray, p_stall, stall_len, fixed_delay, max_delay, rst_cycles;
    bit auto_refill;
    int forced_stall_req = -1;
    int forced_stall_len = 0;

    // Reference state.
    bit              armed = 0, rst_prev = 0, busy = 0, prev_gv = 0, prev_acc = 0;
    bit              acc_last = 0, inflight_last = 0;
    logic [7:0]      acc_byte = 8'h00, inflight_byte = 8'h00;
    int              done_at = 0, owner = 0, last_owner = NREQ - 1;
    logic [NREQ-1:0] prev_valid = '0;

    logic              nxt_rst, nxt_done;
    logic [NREQ-1:0]   nxt_valid, nxt_last;
    logic [8*NREQ-1:0] nxt_data;

    int grant_log[$];
    int start_log[$];
    int start_cyc[$];

    function automatic int rr_pick(input int last, input logic [NREQ-1:0] v);
        int idx;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (last + k) % NREQ;
            if (v[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    task automatic refill(input int i);
        int len;
        len = int'($urandom_range(4, 1));
        for (int b = 0; b < len; b++) rq[i].push_back({1'(b == len - 1), 8'($urandom)});
    endtask

    task automatic sample_check(output logic [NREQ-1:0] acc);
        logic [NREQ-1:0] exp_rdy;
        int              exp_id;
        bit              done_now;
        acc = '0;
        if (rst_prev) begin
            check_eq("rst_tx_start", tx_start, 0);
            check_eq("rst_tx_data", tx_data, 0);
            check_eq("rst_req_ready", req_ready, 0);
            check_eq("rst_grant_valid", grant_valid, 0);
            check_eq("rst_grant_id", grant_id, 0);
            armed = 1; busy = 0; owner = 0; last_owner = NREQ - 1;
        end else if (armed) begin
            done_now = busy && (cyc == done_at + 1);
            if (done_now) busy = 0;
            check_eq("start_vs_accept", tx_start, prev_acc);
            if (tx_start) begin
                check_eq("start_while_busy", busy, 0);
                check_eq("start_data", tx_data, acc_byte);
                start_log.push_back(int'(tx_data));
                start_cyc.push_back(cyc);
                busy          = 1;
                inflight_byte = acc_byte;
                inflight_last = acc_last;
                done_at = cyc + ((fixed_delay > 0) ? fixed_delay : int'($urandom_range(max_delay, 1)));
            end else if (busy) begin
                check_eq("data_stable", tx_data, inflight_byte);
            end
            if (!prev_gv) begin
                check_eq("grant_rise", grant_valid, |prev_valid);
                if (grant_valid) begin
                    exp_id = rr_pick(last_owner, prev_valid);
                    check_eq("grant_rr", grant_id, exp_id);
                    owner = exp_id;
                    grant_log.push_back(exp_id);
                end
            end else begin
                check_eq("grant_keep", grant_valid, done_now ? !inflight_last : 1);
                if (grant_valid) check_eq("grant_hold", grant_id, owner);
                else last_owner = owner;
            end
            exp_rdy = '0;
            if (grant_valid && !busy && !tx_start && owner >= 0) exp_rdy[owner[1:0]] = req_valid[owner[1:0]];
            check_eq("req_ready", req_ready, exp_rdy);
            acc = req_ready & req_valid & {NREQ{!areset}};
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i] && rq[i].size() > 0) begin
                    acc_byte = rq[i][0][7:0];
                    acc_last = rq[i][0][8];
                    void'(rq[i].pop_front());
                    if (i == forced_stall_req && !acc_last) begin
                        hold_off[i]      = forced_stall_len;
                        forced_stall_req = -1;
                    end else if (int'($urandom_range(99)) < p_stall) begin
                        hold_off[i] = int'($urandom_range(stall_len, 1));
                    end
                end
            end
        end
        prev_acc   = |acc;
        prev_gv    = grant_valid;
        prev_valid = req_valid;
        rst_prev   = areset;
    endtask

    task automatic decide(input logic [NREQ-1:0] acc);
        nxt_rst = (rst_cycles > 0);
        if (rst_cycles > 0) rst_cycles--;
        for (int i = 0; i < NREQ; i++) begin
            if (auto_refill && rq[i].size() == 0) refill(i);
            if (req_valid[i] && !acc[i]) begin
                nxt_valid[i] = 1'b1;
            end else if (hold_off[i] > 0) begin
                hold_off[i]--;
                nxt_valid[i] = 1'b0;
            end else begin
                nxt_valid[i] = (rq[i].size() > 0) && (int'($urandom_range(99)) < p_valid);
            end
            if (nxt_valid[i]) begin
                nxt_data[8*i +: 8] = rq[i][0][7:0];
                nxt_last[i]        = rq[i][0][8];
            end else begin
                nxt_data[8*i +: 8] = 8'($urandom);
                nxt_last[i]        = 1'($urandom);
            end
        end
        nxt_done = busy ? (cyc + 1 == done_at) : (int'($urandom_range(99)) < p_stray);
    endtask

    task automatic step();
        logic [NREQ-1:0] acc;
        @(posedge clk);
        #1;
        areset    = nxt_rst;
        req_valid = nxt_valid;
        req_data  = nxt_data;
        req_last  = nxt_last;
        tx_done   = nxt_done;
        @(negedge clk);
        cyc++;
        sample_check(acc);
        decide(acc);
    endtask

    function automatic bit all_idle();
        for (int i = 0; i < NREQ; i++) if (rq[i].size() != 0) return 0;
        return !busy && !grant_valid && !prev_acc;
    endfunction

    task automatic drain(input string tag, input int budget);
        for (int n = 0; n < budget && !all_idle(); n++) step();
        check_eq({tag, "_drained"}, all_idle(), 1);
    endtask

    task automatic check_log(input string tag, input int got[$], input int exp[$]);
        check_eq({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) check_eq(tag, got[i], exp[i]);
    endtask

    task automatic clear_logs();
        grant_log.delete();
        start_log.delete();
        start_cyc.delete();
    endtask

    initial begin
        int gap;
        areset = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_done = 1'b0;
        nxt_rst = 1'b1; nxt_valid = '0; nxt_data = '0; nxt_last = '0; nxt_done = 1'b0;
        rst_cycles = 2; p_valid = 0; p_stray = 0; p_stall = 0; stall_len = 1;
        fixed_delay = 0; max_delay = 6; auto_refill = 0;
        for (int i = 0; i < NREQ; i++) hold_off[i] = 0;
        repeat (4) step();

        // Single byte from requester 2, done 20 cycles after start.
        clear_logs();
        p_valid = 100; fixed_delay = 20;
        rq[2].push_back({1'b1, 8'hA5});
        repeat (40) step();
        check_log("single_bytes", start_log, '{32'hA5});
        check_log("single_grants", grant_log, '{2});
        check_eq("single_grant_valid_end", grant_valid, 0);
        check_eq("single_grant_id_end", grant_id, 2);

        // Fairness: everyone valid, single-byte bursts; search starts after 2.
        clear_logs();
        fixed_delay = 0;
        for (int r = 0; r < NREQ; r++) repeat (3) rq[r].push_back({1'b1, 8'($urandom)});
        drain("fair", 600);
        check_eq("fair_starts", start_log.size(), 12);
        check_eq("fair_grants", grant_log.size(), 12);
        for (int i = 0; i < grant_log.size(); i++) check_eq("fair_order", grant_log[i], (3 + i) % NREQ);

        // Burst lock: requester 1 burst while requester 0 waits.
        rq[0].push_back({1'b1, 8'h55});
        drain("lock_pre", 200);
        clear_logs();
        rq[1].push_back({1'b0, 8'h10});
        rq[1].push_back({1'b0, 8'h11});
        rq[1].push_back({1'b1, 8'h12});
        rq[0].push_back({1'b1, 8'h77});
        drain("lock", 400);
        check_log("lock_bytes", start_log, '{32'h10, 32'h11, 32'h12, 32'h77});
        check_log("lock_grants", grant_log, '{1, 0});

        // Stall in burst: requester 3 drops valid for 50 cycles after its first byte.
        clear_logs();
        forced_stall_req = 3; forced_stall_len = 50;
        rq[3].push_back({1'b0, 8'h30});
        rq[3].push_back({1'b1, 8'h31});
        rq[0].push_back({1'b1, 8'h66});
        drain("stall", 400);
        check_log("stall_bytes", start_log, '{32'h30, 32'h31, 32'h66});
        check_log("stall_grants", grant_log, '{3, 0});
        gap = (start_cyc.size() >= 2) ? start_cyc[1] - start_cyc[0] : 0;
        check_eq("stall_gap_ge_50", int'(gap >= 50), 1);

        // Stray done pulses whenever the transmitter is idle (IDLE/SEND/START).
        clear_logs();
        p_stray = 100;
        rq[1].push_back({1'b0, 8'h42});
        rq[1].push_back({1'b1, 8'h43});
        drain("stray", 300);
        check_log("stray_bytes", start_log, '{32'h42, 32'h43});
        p_stray = 0;

        // Random traffic with stalls and stray done pulses.
        p_valid = 60; p_stray = 15; p_stall = 10; stall_len = 12; auto_refill = 1;
        repeat (2500) step();

        // Reset while waiting for a long transmission.
        fixed_delay = 30;
        for (int n = 0; n < 300 && !busy; n++) step();
        check_eq("reset_found_busy", busy, 1);
        step();
        rst_cycles = 1;
        repeat (3) step();
        fixed_delay = 0;
        repeat (600) step();

        // Drain everything.
        auto_refill = 0; p_valid = 100; p_stall = 0; p_stray = 0;
        drain("final", 3000);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
